regex_instr_mem_responder: RTL and testbench
============================================

Name: regex_instr_mem_responder

Overview:
- Responder end of the instruction-fetch handshake issued by the regex CPUs: memory_valid/memory_addr/memory_ready/memory_data.
- Serves N_PORTS CPU fetch ports from one shared single-port instruction RAM.
- Arbitrates round-robin, one read grant per cycle; returns each word one cycle after the grant.
- Also owns the host programming (write) port that loads the regex program.

Parameters:
N_PORTS, 4, number of CPU fetch ports (1..16)
MEMORY_WIDTH, 16, instruction word width in bits
MEMORY_ADDR_WIDTH, 11, address width; depth = 2**MEMORY_ADDR_WIDTH words

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
memory_valid  input  N_PORTS  per-port fetch request
memory_addr  input  N_PORTS*MEMORY_ADDR_WIDTH  per-port fetch address; port i occupies slice [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
memory_ready  output  N_PORTS  per-port grant; combinational from memory_valid and arbiter state
memory_data  output  N_PORTS*MEMORY_WIDTH  per-port registered read data, same slicing scheme
wr_valid  input  1  host write request
wr_addr  input  MEMORY_ADDR_WIDTH  host write address
wr_data  input  MEMORY_WIDTH  host write data
wr_ready  output  1  host write accepted
Interface: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
Reset:
- memory_ready = 0, wr_ready = 0 during reset.
- All memory_data slices = 0; round-robin pointer = 0.
- RAM contents are not reset.

Write priority:
- When wr_valid = 1, wr_ready = 1 and RAM[wr_addr] <= wr_data at that edge.
- All memory_ready = 0 in that cycle.
- Writes always complete in one cycle and never stall.

Read arbitration, when wr_valid = 0:
- Grant exactly one requesting port: the first with memory_valid = 1, searching from rr_ptr upward with wrap at N_PORTS.
- memory_ready[g] = 1 for the granted port only.
- No requester: all memory_ready = 0 and rr_ptr is unchanged.
- After a grant to port g: rr_ptr <= (g+1) mod N_PORTS.

Read latency:
- A handshake in cycle t (valid & ready) drives memory_data slice g with RAM[addr_g] in cycle t+1.
- The slice holds that value until the next grant to port g. Other ports' slices are unaffected.
- The requester samples exactly one cycle after the handshake; the data must be stable then.

Hazards and state:
- A write at cycle t followed by a read of the same address granted at t+1 returns the new data. Same-cycle write and read cannot occur because write has priority.
- Internal state: a grant-pending register holding (valid, port index) for the RAM output mux. No FSM beyond the arbiter pointer.

Reset mid-operation:
- A grant issued in the reset cycle is dropped.
- Data slices read 0 in the cycle after reset.

N_PORTS = 1: the arbiter degenerates to memory_ready = memory_valid & ~wr_valid.

Optional Feature:
REGEX_MEM_PERF_EN.
- Defined: adds outputs stall_cycles (32 bits) and grant_count (32 bits).
  - stall_cycles increments each cycle in which at least one memory_valid is high but its port is not granted (arbitration loss or write priority).
  - grant_count increments on every read handshake.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Shared package regex_mem_pkg:
  - default width constants MEMORY_WIDTH_DEFAULT = 16 and MEMORY_ADDR_WIDTH_DEFAULT = 11;
  - typedef mem_word_t;
  - function port_slice index helpers.
- Existing instruction package constants (opcode encodings, INSTRUCTION_WIDTH) are reused unchanged. The bench uses them to build program images.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], enable;
  - outputs: grant one-hot[N], grant_idx, grant_valid;
  - holds the pointer internally.
- RAM is inferred in the top module as a single-port synchronous-read array.

Test Plan:
- Write RAM[5]=0x0341 via host, then port 0 valid with addr 5 -> ready[0]=1 same cycle; data slice 0 = 0x0341 in the next cycle and held while idle.
- Ports 0 and 2 both valid from reset, addrs 1 and 2 -> grants in the order port 0, then port 2; each data slice carries its own word one cycle after its grant.
- All 4 ports continuously valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; no port starved.
- wr_valid held high 3 cycles while port 1 requests -> memory_ready[1]=0 for those 3 cycles; granted in the first cycle wr_valid is low.
- Write RAM[9]=0xAAAA at cycle t, port 3 requests addr 9 at t+1 -> data slice 3 = 0xAAAA at t+2.
- Assert reset for one cycle during an active grant -> no memory_ready in the reset cycle; all data slices 0 after; rr_ptr back to 0, so the next simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/regex_mem_pkg.sv
// ============================================================================
// Module  : regex_mem_pkg
// Brief   : Shared width defaults, word type and port-slice helpers for the
//           regex instruction memory responder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regex_mem_pkg;

  localparam int MEMORY_WIDTH_DEFAULT      = 16;
  localparam int MEMORY_ADDR_WIDTH_DEFAULT = 11;

  typedef logic [MEMORY_WIDTH_DEFAULT-1:0] mem_word_t;

  // Low bit of port's slice in a flattened per-port bus.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  function automatic int port_hi(input int port, input int width);
    return (port * width) + width - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin single-grant arbiter; searches upward from an internal
//           pointer that advances past each granted requester.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;
  logic [IDXW-1:0] cand;
  int              idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    ptr_d       = ptr_q;
    idx         = 0;
    cand        = '0;
    if (enable) begin
      // Descending scan so the candidate nearest the pointer wins last.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        cand = IDXW'(idx);
        if (req[cand]) begin
          grant_idx   = cand;
          grant_valid = 1'b1;
        end
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
      ptr_d = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regex_instr_mem_responder.sv
// ============================================================================
// Module  : regex_instr_mem_responder
// Brief   : Shared instruction RAM serving N_PORTS regex CPU fetch ports with
//           round-robin reads and a host write port that has priority.
//           Optional REGEX_MEM_PERF_EN adds stall/grant counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regex_instr_mem_responder
  import regex_mem_pkg::*;
#(
  parameter int N_PORTS           = 4,
  parameter int MEMORY_WIDTH      = MEMORY_WIDTH_DEFAULT,
  parameter int MEMORY_ADDR_WIDTH = MEMORY_ADDR_WIDTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_PORTS-1:0]                   memory_valid,
  input  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic [N_PORTS-1:0]                   memory_ready,
  output logic [N_PORTS*MEMORY_WIDTH-1:0]      memory_data,
  input  logic                                 wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]         wr_addr,
  input  logic [MEMORY_WIDTH-1:0]              wr_data,
  output logic                                 wr_ready
`ifdef REGEX_MEM_PERF_EN
  ,
  output logic [31:0]                          stall_cycles,
  output logic [31:0]                          grant_count
`endif
);

  localparam int DEPTH = 1 << MEMORY_ADDR_WIDTH;
  localparam int IDXW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [MEMORY_WIDTH-1:0] ram [DEPTH];

  logic [N_PORTS-1:0]           grant;
  logic [IDXW-1:0]              grant_idx;
  logic                         grant_valid;
  logic                         arb_en;
  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr;
  logic [MEMORY_WIDTH-1:0]      rd_data_q;

  logic                                   pend_valid_q, pend_valid_d;
  logic [IDXW-1:0]                        pend_idx_q, pend_idx_d;
  logic [N_PORTS-1:0][MEMORY_WIDTH-1:0]   hold_q, hold_d;

  // Host writes pre-empt reads so the single RAM port is never shared.
  assign arb_en   = ~wr_valid & ~reset;
  assign wr_ready = wr_valid & ~reset;

  rr_arbiter #(
    .N    (N_PORTS),
    .IDXW (IDXW)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (memory_valid),
    .enable      (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign memory_ready = grant;

  always_comb begin
    rd_addr = memory_addr[port_lo(int'(grant_idx), MEMORY_ADDR_WIDTH) +: MEMORY_ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (wr_ready) begin
      ram[wr_addr] <= wr_data;
    end else if (grant_valid) begin
      rd_data_q <= ram[rd_addr];
    end
  end

  // The freshly read word is steered to its port's slice in the cycle after
  // the grant, then captured into that port's hold register.
  always_comb begin
    memory_data = hold_q;
    if (pend_valid_q) begin
      memory_data[port_lo(int'(pend_idx_q), MEMORY_WIDTH) +: MEMORY_WIDTH] = rd_data_q;
    end
  end

  always_comb begin
    pend_valid_d = grant_valid;
    pend_idx_d   = grant_idx;
    hold_d       = hold_q;
    if (pend_valid_q) begin
      hold_d[pend_idx_q] = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      hold_q       <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      hold_q       <= hold_d;
    end
  end

`ifdef REGEX_MEM_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] gcnt_q, gcnt_d;

  always_comb begin
    stall_d = stall_q;
    gcnt_d  = gcnt_q;
    if (|(memory_valid & ~grant) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (grant_valid && (gcnt_q != '1)) begin
      gcnt_d = gcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      gcnt_q  <= '0;
    end else begin
      stall_q <= stall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign grant_count  = gcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regex_instr_mem_responder.sv
// ============================================================================
// Module  : tb_regex_instr_mem_responder
// Brief   : Directed self-checking bench for regex_instr_mem_responder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_regex_instr_mem_responder;
  import regex_mem_pkg::*;

  localparam int NP = 4;
  localparam int W  = MEMORY_WIDTH_DEFAULT;
  localparam int AW = MEMORY_ADDR_WIDTH_DEFAULT;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     memory_valid;
  logic [NP*AW-1:0]  memory_addr;
  logic [NP-1:0]     memory_ready;
  logic [NP*W-1:0]   memory_data;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              wr_ready;
`ifdef REGEX_MEM_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       grant_count;
`endif

  int checks   = 0;
  int failures = 0;

  mem_word_t exp_word [NP];

  always #5 clk = ~clk;

  regex_instr_mem_responder #(
    .N_PORTS           (NP),
    .MEMORY_WIDTH      (W),
    .MEMORY_ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memory_valid (memory_valid),
    .memory_addr  (memory_addr),
    .memory_ready (memory_ready),
    .memory_data  (memory_data),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready)
`ifdef REGEX_MEM_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .grant_count  (grant_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    memory_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [W-1:0] slice(input int p);
    return memory_data[p*W +: W];
  endfunction

  task automatic host_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    chk("host_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    memory_valid = 4'b1111;
    memory_addr  = '0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    @(negedge clk);
    chk("reset_ready", 64'(memory_ready), 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd0);
    chk("reset_data", 64'(memory_data), 64'd0);
    tick();
    tick();
    reset        = 1'b0;
    memory_valid = '0;

    host_wr(11'd1, 16'h1111);
    host_wr(11'd2, 16'h2222);
    host_wr(11'd5, 16'h0341);

    // Ports 0 and 2 with pointer at 0
    set_addr(0, 11'd1);
    set_addr(2, 11'd2);
    memory_valid = 4'b0101;
    @(negedge clk);
    chk("p02_grant0", 64'(memory_ready), 64'b0001);
    tick();
    memory_valid = 4'b0100;
    @(negedge clk);
    chk("p02_grant2", 64'(memory_ready), 64'b0100);
    chk("p02_data0", 64'(slice(0)), 64'h1111);
    tick();
    memory_valid = '0;
    @(negedge clk);
    chk("p02_data2", 64'(slice(2)), 64'h2222);
    chk("p02_data0_held", 64'(slice(0)), 64'h1111);
    tick();

    // Port 0 reads addr 5 (pointer at 3 wraps to 0)
    set_addr(0, 11'd5);
    memory_valid = 4'b0001;
    @(negedge clk);
    chk("a5_ready", 64'(memory_ready), 64'b0001);
    tick();
    memory_valid = '0;
    @(negedge clk);
    chk("a5_data", 64'(slice(0)), 64'h0341);
    tick();
    @(negedge clk);
    chk("a5_hold", 64'(slice(0)), 64'h0341);
    tick();

    // Reset during an active grant, then continuous requests from all ports
    set_addr(0, 11'd1);
    set_addr(1, 11'd2);
    set_addr(2, 11'd5);
    set_addr(3, 11'd1);
    exp_word[0] = 16'h1111;
    exp_word[1] = 16'h2222;
    exp_word[2] = 16'h0341;
    exp_word[3] = 16'h1111;
    memory_valid = 4'b1111;
    @(negedge clk);
    chk("pre_reset_grant1", 64'(memory_ready), 64'b0010);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ready", 64'(memory_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_reset_data", 64'(memory_data), 64'd0);
      end else begin
        chk($sformatf("rr_data_k%0d", k), 64'(slice((k - 1) % NP)), 64'(exp_word[(k - 1) % NP]));
      end
      chk($sformatf("rr_grant_k%0d", k), 64'(memory_ready), 64'(4'b0001 << (k % NP)));
      tick();
    end
    memory_valid = '0;
    @(negedge clk);
    chk("rr_data_last", 64'(slice(3)), 64'h1111);
    chk("rr_data_p2", 64'(slice(2)), 64'h0341);
    tick();

    // Write priority holds off port 1 for three cycles
    set_addr(1, 11'd2);
    memory_valid = 4'b0010;
    wr_valid     = 1'b1;
    wr_addr      = 11'd7;
    wr_data      = 16'h7777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("wprio_ready_c%0d", c), 64'(memory_ready), 64'd0);
      chk($sformatf("wprio_wr_ready_c%0d", c), 64'(wr_ready), 64'd1);
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wprio_grant1", 64'(memory_ready), 64'b0010);
    tick();
    memory_valid = '0;
    @(negedge clk);
    chk("wprio_data1", 64'(slice(1)), 64'h2222);
    tick();

    // Write-then-read of the same address on consecutive cycles
    host_wr(11'd9, 16'hAAAA);
    set_addr(3, 11'd9);
    memory_valid = 4'b1000;
    @(negedge clk);
    chk("haz_ready3", 64'(memory_ready), 64'b1000);
    tick();
    memory_valid = '0;
    @(negedge clk);
    chk("haz_data3", 64'(slice(3)), 64'hAAAA);
    chk("haz_data1_kept", 64'(slice(1)), 64'h2222);
    tick();

    // The address 7 written under priority is readable
    set_addr(1, 11'd7);
    memory_valid = 4'b0010;
    @(negedge clk);
    chk("a7_ready1", 64'(memory_ready), 64'b0010);
    tick();
    memory_valid = '0;
    @(negedge clk);
    chk("a7_data1", 64'(slice(1)), 64'h7777);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
